// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 16x oversampling and majority vote.
// Words land in a small first-word-fall-through FIFO with sticky error flags.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 fifo_full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 clr_err
);

  localparam int DIVR = BAUD * OVERSAMPLE;
  localparam int DIVC = (CLK_FREQ + DIVR / 2) / DIVR;
  localparam int DIV  = (DIVC < 1) ? 1 : DIVC;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int BW   = 4;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int S0   = OVERSAMPLE / 2 - 1;
  localparam int S1   = OVERSAMPLE / 2;
  localparam int S2   = OVERSAMPLE / 2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, sync3_q;
  logic [DW-1:0]        div_q, div_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bad_q, bad_d;
  logic                 push_q, push_d;
  logic [DATA_BITS-1:0] pword_q, pword_d;
  logic                 set_fe, set_pe;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valid_q, full_q;
  logic                 fe_q, pe_q, ov_q;

  logic tick, fall, vote_now, vote;
  logic pop, wr_ok, set_ov, par_x;

  assign tick = (div_q == DW'(DIV - 1));
  assign fall = sync3_q & ~sync2_q;
  assign vote_now = tick & (tick_q == TW'(S2));
  assign vote = (smp_q[0] & smp_q[1]) |
                (smp_q[0] & sync2_q) |
                (smp_q[1] & sync2_q);
  assign par_x = ^shift_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bad_d   = bad_q;
    smp_d   = smp_q;
    push_d  = 1'b0;
    pword_d = pword_q;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    div_d   = tick ? '0 : div_q + 1'b1;
    tick_d  = tick_q;
    if (tick) begin
      if (tick_q == TW'(OVERSAMPLE - 1))
        tick_d = '0;
      else
        tick_d = tick_q + 1'b1;
    end
    if (tick && tick_q == TW'(S0))
      smp_d[0] = sync2_q;
    if (tick && tick_q == TW'(S1))
      smp_d[1] = sync2_q;
    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (fall) begin
          div_d   = '0;
          bit_d   = '0;
          bad_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (vote_now)
          state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY
                                    : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (vote_now) begin
          if (PARITY == 1)
            bad_d = ~(par_x ^ vote);
          else
            bad_d = par_x ^ vote;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (vote_now) begin
          if (!vote) begin
            set_fe  = 1'b1;
            state_d = ST_WAIT;
          end else if (bit_q == BW'(STOP_BITS - 1)) begin
            // Leave early so a gapless next start edge is seen
            state_d = ST_IDLE;
            if (bad_q) begin
              set_pe = 1'b1;
            end else begin
              push_d  = 1'b1;
              pword_d = shift_q;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        tick_d = '0;
        if (sync2_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      bad_q   <= 1'b0;
      push_q  <= 1'b0;
      pword_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      bad_q   <= bad_d;
      push_q  <= push_d;
      pword_q <= pword_d;
    end
  end

  assign pop    = rd_en & valid_q;
  assign wr_ok  = push_q & (~full_q | pop);
  assign set_ov = push_q & full_q & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_ok && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (!wr_ok && pop)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_ok)
      mem_q[wptr_q] <= pword_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (wr_ok)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      full_q  <= (cnt_d == CW'(FIFO_DEPTH));
      fe_q    <= set_fe | (fe_q & ~clr_err);
      pe_q    <= set_pe | (pe_q & ~clr_err);
      ov_q    <= set_ov | (ov_q & ~clr_err);
    end
  end

  assign rd_data    = valid_q ? mem_q[rptr_q] : '0;
  assign rd_valid   = valid_q;
  assign fifo_full  = full_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances with different line settings.
// Frames are built from the line format; a queue model tracks FIFO and flags.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset;
  logic       clr_err;
  logic       rx_l    [3];
  logic       rd_en_l [3];
  logic       rdv     [3];
  logic       ful     [3];
  logic       fe      [3];
  logic       pe      [3];
  logic       ov      [3];
  logic [8:0] rdd     [3];
  logic [7:0] rda;
  logic [6:0] rdb;
  logic [8:0] rdc;

  int total = 0;
  int bad   = 0;

  assign rdd[0] = {1'b0, rda};
  assign rdd[1] = {2'b0, rdb};
  assign rdd[2] = rdc;

  uart_rx_param #(
    .CLK_FREQ(50000000), .BAUD(115200)
  ) u_a (
    .CLOCK_50(clk), .reset(reset), .rx(rx_l[0]),
    .rd_en(rd_en_l[0]), .rd_data(rda),
    .rd_valid(rdv[0]), .fifo_full(ful[0]),
    .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun(ov[0]), .clr_err(clr_err)
  );

  uart_rx_param #(
    .CLK_FREQ(50000000), .BAUD(460800),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .CLOCK_50(clk), .reset(reset), .rx(rx_l[1]),
    .rd_en(rd_en_l[1]), .rd_data(rdb),
    .rd_valid(rdv[1]), .fifo_full(ful[1]),
    .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun(ov[1]), .clr_err(clr_err)
  );

  uart_rx_param #(
    .CLK_FREQ(50000000), .BAUD(1000000),
    .OVERSAMPLE(8), .DATA_BITS(9), .PARITY(1)
  ) u_c (
    .CLOCK_50(clk), .reset(reset), .rx(rx_l[2]),
    .rd_en(rd_en_l[2]), .rd_data(rdc),
    .rd_valid(rdv[2]), .fifo_full(ful[2]),
    .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun(ov[2]), .clr_err(clr_err)
  );

  // Bit period = round(50e6/(BAUD*OS)) * OS clocks
  function automatic int bitclk(input int ch);
    case (ch)
      0: return 432;
      1: return 112;
      default: return 48;
    endcase
  endfunction

  function automatic int dbits(input int ch);
    case (ch)
      0: return 8;
      1: return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int pmode(input int ch);
    case (ch)
      0: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int nstop(input int ch);
    return (ch == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_st(input int ch, input string t,
                        input int v, input int f,
                        input int e_f, input int e_p,
                        input int e_o);
    chk({t, "_valid"}, 32'(rdv[ch]), v);
    chk({t, "_full"}, 32'(ful[ch]), f);
    chk({t, "_ferr"}, 32'(fe[ch]), e_f);
    chk({t, "_perr"}, 32'(pe[ch]), e_p);
    chk({t, "_ovr"}, 32'(ov[ch]), e_o);
  endtask

  task automatic send_frame(input int ch,
                            input logic [8:0] d,
                            input bit flip,
                            input bit bstop,
                            input int hold,
                            input int gbit,
                            input int nlim);
    logic [15:0] bits;
    logic        p;
    int          n;
    int          bc;
    bc   = bitclk(ch);
    bits = '1;
    bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < dbits(ch); i++) begin
      bits[1+i] = d[i];
      p ^= d[i];
    end
    n = 1 + dbits(ch);
    if (pmode(ch) == 1)
      p = ~p;
    p ^= flip;
    if (pmode(ch) != 0) begin
      bits[n] = p;
      n++;
    end
    if (bstop) begin
      bits[n] = 1'b0;
      n++;
    end else begin
      for (int s = 0; s < nstop(ch); s++) begin
        bits[n] = 1'b1;
        n++;
      end
    end
    if (nlim > 0)
      n = nlim;
    for (int i = 0; i < n; i++) begin
      rx_l[ch] = bits[i];
      for (int c = 0; c < bc; c++) begin
        if (i == gbit && c == bc / 2)
          rx_l[ch] = ~bits[i];
        if (i == gbit && c == bc / 2 + 1)
          rx_l[ch] = bits[i];
        @(negedge clk);
      end
    end
    if (bstop) begin
      repeat (hold * bc) @(negedge clk);
      rx_l[ch] = 1'b1;
    end
  endtask

  task automatic send(input int ch, input logic [8:0] d);
    send_frame(ch, d, 1'b0, 1'b0, 0, -1, 0);
  endtask

  task automatic idle(input int ch, input int n);
    repeat (n * bitclk(ch)) @(negedge clk);
  endtask

  task automatic pop_chk(input int ch, input logic [8:0] e,
                         input string t);
    chk({t, "_v"}, 32'(rdv[ch]), 1);
    chk(t, 32'(rdd[ch]), 32'(e));
    rd_en_l[ch] = 1'b1;
    @(negedge clk);
    rd_en_l[ch] = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test1();
    send(0, 9'h55);
    chk("t1_valid_mid", 32'(rdv[0]), 1);
    send(0, 9'hAA);
    send(0, 9'h3C);
    idle(0, 1);
    pop_chk(0, 9'h55, "t1_d0");
    pop_chk(0, 9'hAA, "t1_d1");
    pop_chk(0, 9'h3C, "t1_d2");
    chk_st(0, "t1_end", 0, 0, 0, 0, 0);
  endtask

  task automatic test2();
    rx_l[0] = 1'b0;
    repeat (100) @(negedge clk);
    rx_l[0] = 1'b1;
    idle(0, 2);
    chk_st(0, "t2_false", 0, 0, 0, 0, 0);
    send_frame(0, 9'hA5, 1'b0, 1'b0, 0, 3, 0);
    idle(0, 1);
    pop_chk(0, 9'hA5, "t2_glitch");
    chk_st(0, "t2_end", 0, 0, 0, 0, 0);
  endtask

  task automatic test3();
    send(1, 9'h41);
    idle(1, 1);
    pop_chk(1, 9'h41, "t3_good");
    chk_st(1, "t3_good", 0, 0, 0, 0, 0);
    send_frame(1, 9'h41, 1'b1, 1'b0, 0, -1, 0);
    idle(1, 1);
    chk_st(1, "t3_perr", 0, 0, 0, 1, 0);
    pulse_clr();
    chk("t3_clr", 32'(pe[1]), 0);
    send(1, 9'h2A);
    idle(1, 1);
    pop_chk(1, 9'h2A, "t3_after");
  endtask

  task automatic test4();
    send_frame(0, 9'h12, 1'b0, 1'b1, 3, -1, 0);
    idle(0, 1);
    chk_st(0, "t4_ferr", 0, 0, 1, 0, 0);
    send(0, 9'h34);
    idle(0, 1);
    pop_chk(0, 9'h34, "t4_next");
    chk("t4_sticky", 32'(fe[0]), 1);
    pulse_clr();
    chk("t4_clr", 32'(fe[0]), 0);
  endtask

  task automatic test5();
    int n;
    int lat;
    n = 0;
    fork
      send(2, 9'h01);
      begin
        while (rdv[2] !== 1'b1 && n < 960) begin
          @(negedge clk);
          n++;
        end
      end
    join
    chk("t5_lat_bound", 32'(n < 960), 1);
    lat = (n < 1) ? 1 : n;
    idle(2, 1);
    for (int i = 2; i <= 4; i++) begin
      send(2, 9'(i));
      idle(2, 1);
    end
    chk("t5_full4", 32'(ful[2]), 1);
    send(2, 9'h05);
    idle(2, 1);
    chk_st(2, "t5_ovr", 1, 1, 0, 0, 1);
    for (int i = 1; i <= 4; i++)
      pop_chk(2, 9'(i), "t5_rd");
    chk_st(2, "t5_empty", 0, 0, 0, 0, 1);
    pulse_clr();
    chk("t5_clr", 32'(ov[2]), 0);
    for (int i = 'h11; i <= 'h14; i++) begin
      send(2, 9'(i));
      idle(2, 1);
    end
    chk("t5_full4b", 32'(ful[2]), 1);
    fork
      send(2, 9'h15);
      begin
        repeat (lat - 1) @(negedge clk);
        rd_en_l[2] = 1'b1;
        @(negedge clk);
        rd_en_l[2] = 1'b0;
      end
    join
    idle(2, 1);
    chk_st(2, "t5_same", 1, 1, 0, 0, 0);
    for (int i = 'h12; i <= 'h15; i++)
      pop_chk(2, 9'(i), "t5_rd2");
    chk_st(2, "t5_end", 0, 0, 0, 0, 0);
  endtask

  task automatic rand_test();
    logic [8:0] q[$];
    logic [8:0] d;
    int         k;
    bit         mfe, mpe, mov;
    mfe = 0; mpe = 0; mov = 0;
    for (int it = 0; it < 24; it++) begin
      d = 9'($urandom_range(0, 511));
      k = $urandom_range(0, 9);
      if (k < 7) begin
        send(2, d);
        if (q.size() < 4) q.push_back(d);
        else mov = 1;
      end else if (k == 7) begin
        send_frame(2, d, 1'b1, 1'b0, 0, -1, 0);
        mpe = 1;
      end else begin
        send_frame(2, d, 1'($urandom_range(0, 1)),
                   1'b1, 1, -1, 0);
        mfe = 1;
      end
      idle(2, 1);
      chk_st(2, "rnd", int'(q.size() > 0),
             int'(q.size() == 4), mfe, mpe, mov);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if (q.size() > 0)
          pop_chk(2, q.pop_front(), "rnd_rd");
      end
      if ($urandom_range(0, 5) == 0) begin
        pulse_clr();
        mfe = 0; mpe = 0; mov = 0;
      end
    end
  endtask

  task automatic test6();
    send(0, 9'h61);
    idle(0, 1);
    send(0, 9'h62);
    idle(0, 1);
    chk("t6_queued", 32'(rdv[0]), 1);
    send_frame(0, 9'h77, 1'b0, 1'b0, 0, -1, 5);
    rx_l[0] = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    chk_st(0, "t6_rst", 0, 0, 0, 0, 0);
    chk("t6_rst_data", 32'(rdd[0]), 0);
    idle(0, 1);
    send(0, 9'h88);
    idle(0, 1);
    pop_chk(0, 9'h88, "t6_fresh");
    chk_st(0, "t6_end", 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    clr_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_l[i]    = 1'b1;
      rd_en_l[i] = 1'b0;
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk_st(i, "reset", 0, 0, 0, 0, 0);
    fork
      begin
        test1();
        test2();
      end
      begin
        test5();
        rand_test();
      end
    join
    test3();
    test4();
    test6();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
